// File: rtl/cbus_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cbus_mem_arbiter_if
// Purpose  : Bundle of the two CBUS requester ports and the SRAM port seen by
//            cbus_mem_arbiter. slave = arbiter side, master = requesters/SRAM.
// Revision : 1.0 - initial release
// ============================================================================
interface cbus_mem_arbiter_if #(
    parameter int DW = 64,
    parameter int AW = 12
);
    logic          p0_req;
    logic          p0_cmd;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wrdata;
    logic          p0_waccept;
    logic          p0_rresp;
    logic [DW-1:0] p0_rd_data;

    logic          p1_req;
    logic          p1_cmd;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wrdata;
    logic          p1_waccept;
    logic          p1_rresp;
    logic [DW-1:0] p1_rd_data;

    logic          mem_stall;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wrdata;
    logic [DW-1:0] mem_rddata;

    modport slave (
        input  p0_req, p0_cmd, p0_addr, p0_wrdata,
        output p0_waccept, p0_rresp, p0_rd_data,
        input  p1_req, p1_cmd, p1_addr, p1_wrdata,
        output p1_waccept, p1_rresp, p1_rd_data,
        input  mem_stall, mem_rddata,
        output mem_cs, mem_we, mem_addr, mem_wrdata
    );

    modport master (
        output p0_req, p0_cmd, p0_addr, p0_wrdata,
        input  p0_waccept, p0_rresp, p0_rd_data,
        output p1_req, p1_cmd, p1_addr, p1_wrdata,
        input  p1_waccept, p1_rresp, p1_rd_data,
        output mem_stall, mem_rddata,
        input  mem_cs, mem_we, mem_addr, mem_wrdata
    );
endinterface
`default_nettype wire

// File: rtl/cbus_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cbus_mem_arbiter
// Purpose  : Two-port CBUS arbiter in front of a single-port 1-cycle SRAM;
//            one grant per cycle, round-robin or fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module cbus_mem_arbiter #(
    parameter int DW    = 64,
    parameter int AW    = 12,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             sreset_n,
    cbus_mem_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    logic          w_gnt_vld;
    port_e         w_gnt_port;
    logic          w_gnt_cmd;
    logic          w_gnt_rd;

    port_e         r_prio_ptr;
    logic          r_rd_pend;
    port_e         r_rd_port;
    logic [DW-1:0] r_hold0;
    logic [DW-1:0] r_hold1;

    // Request lines are combinational into the grant, so gate with reset to
    // keep every response low while sreset_n is asserted.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_port = PORT0;
        if (sreset_n && !bus.mem_stall) begin
            case ({bus.p1_req, bus.p0_req})
                2'b01: begin
                    w_gnt_vld  = 1'b1;
                    w_gnt_port = PORT0;
                end
                2'b10: begin
                    w_gnt_vld  = 1'b1;
                    w_gnt_port = PORT1;
                end
                2'b11: begin
                    w_gnt_vld  = 1'b1;
                    w_gnt_port = RR_EN ? r_prio_ptr : PORT0;
                end
                default: begin
                    w_gnt_vld  = 1'b0;
                    w_gnt_port = PORT0;
                end
            endcase
        end
    end

    assign w_gnt_cmd = (w_gnt_port == PORT1) ? bus.p1_cmd : bus.p0_cmd;
    assign w_gnt_rd  = w_gnt_vld & w_gnt_cmd;

    always_comb begin
        bus.mem_cs     = w_gnt_vld;
        bus.mem_we     = w_gnt_vld & ~w_gnt_cmd;
        bus.mem_addr   = '0;
        bus.mem_wrdata = '0;
        if (w_gnt_vld) begin
            bus.mem_addr   = (w_gnt_port == PORT1) ? bus.p1_addr   : bus.p0_addr;
            bus.mem_wrdata = (w_gnt_port == PORT1) ? bus.p1_wrdata : bus.p0_wrdata;
        end
    end

    assign bus.p0_waccept = w_gnt_vld && (w_gnt_port == PORT0) && !bus.p0_cmd;
    assign bus.p0_rresp   = w_gnt_vld && (w_gnt_port == PORT0) &&  bus.p0_cmd;
    assign bus.p1_waccept = w_gnt_vld && (w_gnt_port == PORT1) && !bus.p1_cmd;
    assign bus.p1_rresp   = w_gnt_vld && (w_gnt_port == PORT1) &&  bus.p1_cmd;

    always_ff @(posedge clk or negedge sreset_n) begin
        if (!sreset_n) begin
            r_prio_ptr <= PORT0;
            r_rd_pend  <= 1'b0;
            r_rd_port  <= PORT0;
        end else begin
            if (RR_EN && w_gnt_vld) begin
                r_prio_ptr <= (w_gnt_port == PORT0) ? PORT1 : PORT0;
            end
            r_rd_pend <= w_gnt_rd;
            if (w_gnt_rd) begin
                r_rd_port <= w_gnt_port;
            end
        end
    end

    // SRAM data is bypassed in its arrival cycle and captured for later cycles.
    always_ff @(posedge clk or negedge sreset_n) begin
        if (!sreset_n) begin
            r_hold0 <= '0;
            r_hold1 <= '0;
        end else if (r_rd_pend) begin
            if (r_rd_port == PORT0) begin
                r_hold0 <= bus.mem_rddata;
            end else begin
                r_hold1 <= bus.mem_rddata;
            end
        end
    end

    assign bus.p0_rd_data = (r_rd_pend && (r_rd_port == PORT0)) ? bus.mem_rddata : r_hold0;
    assign bus.p1_rd_data = (r_rd_pend && (r_rd_port == PORT1)) ? bus.mem_rddata : r_hold1;

endmodule
`default_nettype wire

// File: tb/tb_cbus_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cbus_mem_arbiter
// Purpose  : Scoreboard bench for cbus_mem_arbiter (round-robin instance plus
//            a fixed-priority instance) with a behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cbus_mem_arbiter;
    localparam int DW = 64;
    localparam int AW = 12;

    typedef struct packed {
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic sreset_n = 1'b0;
    always #5 clk = ~clk;

    cbus_mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();
    cbus_mem_arbiter_if #(.DW(DW), .AW(AW)) fpb ();

    cbus_mem_arbiter #(.DW(DW), .AW(AW), .RR_EN(1'b1)) dut (
        .clk(clk), .sreset_n(sreset_n), .bus(bus.slave));
    cbus_mem_arbiter #(.DW(DW), .AW(AW), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .sreset_n(sreset_n), .bus(fpb.slave));

    // Behavioural single-port SRAM, 1-cycle read latency
    logic [DW-1:0] sram [2**AW];
    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wrdata;
            else            bus.mem_rddata     <= sram[bus.mem_addr];
        end
    end
    assign fpb.mem_rddata = '0;

    // Reference model state
    logic [DW-1:0] ref_mem [2**AW];
    exp_t          q0[$];
    exp_t          q1[$];
    logic [DW-1:0] exp_cur [2];
    int            turn = 0;
    bit            mon_en = 1'b0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int p, input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.p0_req = 1'b1; bus.p0_cmd = r; bus.p0_addr = a; bus.p0_wrdata = d;
        end else begin
            bus.p1_req = 1'b1; bus.p1_cmd = r; bus.p1_addr = a; bus.p1_wrdata = d;
        end
    endtask

    task automatic idle(input int p);
        if (p == 0) begin
            bus.p0_req = 1'b0; bus.p0_cmd = 1'b0; bus.p0_addr = '0; bus.p0_wrdata = '0;
        end else begin
            bus.p1_req = 1'b0; bus.p1_cmd = 1'b0; bus.p1_addr = '0; bus.p1_wrdata = '0;
        end
    endtask

    function automatic bit resp(input int p);
        if (p == 0) return bus.p0_waccept | bus.p0_rresp;
        return bus.p1_waccept | bus.p1_rresp;
    endfunction

    // Called just after a rising edge; returns just after the edge that
    // completes the transaction. lat = cycles waited before the response.
    task automatic issue(input int p, input bit r, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int lat);
        exp_t e;
        e.rd   = r;
        e.data = r ? ref_mem[a] : '0;
        if (!r) ref_mem[a] = d;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
        drive(p, r, a, d);
        lat = 0;
        forever begin
            @(negedge clk);
            if (resp(p)) break;
            lat++;
            if (lat > 200) begin
                n_cmp++; n_err++;
                $display("FAIL p%0d_timeout: no response after %0d cycles, required one", p, lat);
                break;
            end
        end
        @(posedge clk); #1;
        idle(p);
    endtask

    task automatic rand_port(input int p, input int n);
        int            lat;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            r;
        for (int k = 0; k < 16; k++) begin
            a = AW'((p << (AW-1)) | 'h100 | k);
            d = DW'({$urandom, $urandom});
            issue(p, 1'b0, a, d, lat);
        end
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            a = AW'((p << (AW-1)) | 'h100 | $urandom_range(0, 15));
            d = DW'({$urandom, $urandom});
            r = 1'($urandom_range(0, 1));
            issue(p, r, a, d, lat);
        end
    endtask

    // Monitor: arbitration rules, SRAM port, scoreboard pops and read data
    logic [1:0]    m_req, m_cmd, m_wa, m_rr;
    logic [AW-1:0] m_ad [2];
    logic [DW-1:0] m_wd [2];
    logic [DW-1:0] m_rd [2];
    int            exp_g;
    exp_t          m_e;
    always @(negedge clk) begin
        if (mon_en && sreset_n) begin
            m_req = {bus.p1_req, bus.p0_req};
            m_cmd = {bus.p1_cmd, bus.p0_cmd};
            m_wa  = {bus.p1_waccept, bus.p0_waccept};
            m_rr  = {bus.p1_rresp, bus.p0_rresp};
            m_ad[0] = bus.p0_addr;    m_ad[1] = bus.p1_addr;
            m_wd[0] = bus.p0_wrdata;  m_wd[1] = bus.p1_wrdata;
            m_rd[0] = bus.p0_rd_data; m_rd[1] = bus.p1_rd_data;
            exp_g = -1;
            if (!bus.mem_stall) begin
                if (m_req == 2'b11) exp_g = turn;
                else if (m_req[0])  exp_g = 0;
                else if (m_req[1])  exp_g = 1;
            end
            chk("mem_cs", bus.mem_cs, exp_g >= 0);
            if (exp_g >= 0) begin
                chk("mem_we", bus.mem_we, !m_cmd[exp_g]);
                chk("mem_addr", bus.mem_addr, m_ad[exp_g]);
                chk("mem_wrdata", bus.mem_wrdata, m_wd[exp_g]);
                turn = 1 - exp_g;
            end else begin
                chk("idle_mem_we", bus.mem_we, 0);
                chk("idle_mem_addr", bus.mem_addr, 0);
                chk("idle_mem_wrdata", bus.mem_wrdata, 0);
            end
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("p%0d_waccept", p), m_wa[p], (exp_g == p) && !m_cmd[p]);
                chk($sformatf("p%0d_rresp", p), m_rr[p], (exp_g == p) && m_cmd[p]);
                chk($sformatf("p%0d_rd_data", p), m_rd[p], exp_cur[p]);
                if (m_wa[p] || m_rr[p]) begin
                    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                        n_cmp++; n_err++;
                        $display("FAIL p%0d_unexpected_resp: got a response, required none", p);
                    end else begin
                        if (p == 0) m_e = q0.pop_front();
                        else        m_e = q1.pop_front();
                        chk($sformatf("p%0d_kind", p), m_rr[p], m_e.rd);
                        if (m_rr[p]) exp_cur[p] = m_e.data;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, g0, g1;
        bit rdone;
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
        exp_cur[0] = '0; exp_cur[1] = '0;
        idle(0); idle(1);
        bus.mem_stall = 1'b0;
        fpb.mem_stall = 1'b0;
        fpb.p0_req = 1'b0; fpb.p0_cmd = 1'b0; fpb.p0_addr = '0; fpb.p0_wrdata = '0;
        fpb.p1_req = 1'b0; fpb.p1_cmd = 1'b0; fpb.p1_addr = '0; fpb.p1_wrdata = '0;

        // Reset: outputs must stay low even with requests present
        repeat (2) @(posedge clk); #1;
        bus.p0_req = 1'b1; bus.p0_cmd = 1'b1; bus.p1_req = 1'b1;
        #1;
        chk("rst_p0_rresp", bus.p0_rresp, 0);
        chk("rst_p1_waccept", bus.p1_waccept, 0);
        chk("rst_mem_cs", bus.mem_cs, 0);
        chk("rst_p0_rd_data", bus.p0_rd_data, 0);
        idle(0); idle(1);
        @(negedge clk); sreset_n = 1'b1; mon_en = 1'b1;
        @(posedge clk); #1;

        // Single write then read
        issue(0, 1'b0, AW'('h005), 64'h1122334455667788, lat);
        chk("wr_latency", lat, 0);
        issue(0, 1'b1, AW'('h005), '0, lat);
        chk("rd_latency", lat, 0);
        repeat (3) @(negedge clk);
        chk("rd_held", bus.p0_rd_data, 64'h1122334455667788);
        @(posedge clk); #1;

        // Round-robin contention on continuous reads
        issue(0, 1'b0, AW'('h010), 64'h0101010110101010, lat);
        issue(1, 1'b0, AW'('h020), 64'h0202020220202020, lat);
        fork
            for (int k = 0; k < 4; k++) issue(0, 1'b1, AW'('h010), '0, lat);
            for (int k = 0; k < 4; k++) issue(1, 1'b1, AW'('h020), '0, lat);
        join

        // Hold isolation
        issue(0, 1'b0, AW'('h030), {4{16'hAAAA}}, lat);
        issue(1, 1'b0, AW'('h031), {4{16'h5555}}, lat);
        issue(0, 1'b1, AW'('h030), '0, lat);
        issue(1, 1'b1, AW'('h031), '0, lat);
        repeat (3) @(negedge clk);
        chk("hold_iso_p0", bus.p0_rd_data, {4{16'hAAAA}});
        @(posedge clk); #1;

        // Stall for 3 cycles with a pending p1 write
        bus.mem_stall = 1'b1;
        fork
            begin
                issue(1, 1'b0, AW'('h040), 64'hDEADBEEFCAFEF00D, lat);
                chk("stall_release_latency", lat, 3);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_mem_cs", bus.mem_cs, 0);
                    chk("stall_p1_waccept", bus.p1_waccept, 0);
                end
                @(posedge clk); #1;
                bus.mem_stall = 1'b0;
            end
        join

        // Randomized traffic with random stalls
        rdone = 1'b0;
        fork
            begin
                fork
                    rand_port(0, 120);
                    rand_port(1, 120);
                join
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk); #1;
                    bus.mem_stall = ($urandom_range(0, 99) < 15);
                end
                bus.mem_stall = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        chk("p0_queue_empty", q0.size(), 0);
        chk("p1_queue_empty", q1.size(), 0);

        // Fixed priority instance: both request for 4 cycles
        @(posedge clk); #1;
        fpb.p0_req = 1'b1; fpb.p0_cmd = 1'b1;
        fpb.p1_req = 1'b1; fpb.p1_cmd = 1'b1;
        g0 = 0; g1 = 0;
        repeat (4) begin
            @(negedge clk);
            g0 += int'(fpb.p0_rresp);
            g1 += int'(fpb.p1_rresp);
        end
        @(posedge clk); #1;
        fpb.p0_req = 1'b0; fpb.p1_req = 1'b0;
        chk("fp_p0_grants", g0, 4);
        chk("fp_p1_grants", g1, 0);

        // Asynchronous reset in the middle of a read
        mon_en = 1'b0;
        @(posedge clk); #1;
        drive(0, 1'b1, AW'('h005), '0);
        @(negedge clk);
        chk("mid_rst_rresp_before", bus.p0_rresp, 1);
        @(posedge clk); #2;
        chk("mid_rst_bypass_before", bus.p0_rd_data, 64'h1122334455667788);
        sreset_n = 1'b0;
        #1;
        chk("mid_rst_p0_rd_data", bus.p0_rd_data, 0);
        chk("mid_rst_p1_rd_data", bus.p1_rd_data, 0);
        chk("mid_rst_p0_rresp", bus.p0_rresp, 0);
        chk("mid_rst_mem_cs", bus.mem_cs, 0);
        chk("mid_rst_mem_addr", bus.mem_addr, 0);
        idle(0);
        repeat (2) @(posedge clk);
        @(negedge clk); sreset_n = 1'b1;
        #1;
        chk("post_rst_p0_rd_data", bus.p0_rd_data, 0);
        @(posedge clk); #1;
        drive(0, 1'b1, AW'('h005), '0);
        drive(1, 1'b1, AW'('h020), '0);
        @(negedge clk);
        chk("post_rst_p0_first", bus.p0_rresp, 1);
        chk("post_rst_p1_waits", bus.p1_rresp, 0);
        @(posedge clk); #1;
        idle(0); idle(1);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
